// File: rtl/seq_tx_pkg.sv
// Shared constants and state encoding for the serial pattern transmitter.
// SEQ_TX_GAP_EN selects whether the GAP state is reachable in seq_pattern_tx.
package seq_tx_pkg;

    localparam int SEQ_TX_WIDTH = 4;
    localparam int SEQ_TX_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_GAP   = 3'd2,
        ST_DONE  = 3'd3
    } state_t;

    // Bit-counter width: must hold WIDTH-1.
    function automatic int bitcnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/serial-output bundle for seq_pattern_tx.
// The master side issues start/pattern/repeat_n; the slave side (the transmitter) drives the rest.
interface seq_pattern_tx_if
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = SEQ_TX_WIDTH,
    parameter int CNT_W = SEQ_TX_CNT_W
) ();

    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic [2:0]       cs;
    logic [2:0]       ns;

    modport master (
        output start, pattern, repeat_n,
        input  out, out_valid, busy, done, cs, ns
    );

    modport slave (
        input  start, pattern, repeat_n,
        output out, out_valid, busy, done, cs, ns
    );

endinterface

// File: rtl/seq_tx_shreg.sv
// Loadable MSB-first shift register with bit counter and a private copy of the
// captured pattern so repeated frames reload without looking at the live input.
module seq_tx_shreg
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = SEQ_TX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_reload,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_pattern,
    output logic             o_msb,
    output logic             o_bit_zero
);

    localparam int BW = bitcnt_w(WIDTH);

    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_pat;
    logic [BW-1:0]    r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh  <= '0;
            r_pat <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= i_pattern;
            r_pat <= i_pattern;
            r_cnt <= BW'(WIDTH - 1);
        end else if (i_reload) begin
            r_sh  <= r_pat;
            r_cnt <= BW'(WIDTH - 1);
        end else if (i_shift) begin
            r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - BW'(1);
        end
    end

    assign o_msb      = r_sh[WIDTH-1];
    assign o_bit_zero = (r_cnt == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a WIDTH-bit pattern MSB first, repeat_n+1 times.
// Define SEQ_TX_GAP_EN to insert one idle GAP cycle between repeated frames.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = SEQ_TX_WIDTH,
    parameter int CNT_W = SEQ_TX_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    seq_pattern_tx_if.slave   bus
);

    state_t           r_state;
    state_t           w_ns;
    logic [CNT_W-1:0] r_frames;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic             w_reload;
    logic             w_shift;
    logic             w_msb;
    logic             w_bit_zero;

    always_comb begin
        w_ns     = r_state;
        w_load   = 1'b0;
        w_reload = 1'b0;
        w_shift  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_ns   = ST_SHIFT;
                    w_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!w_bit_zero) begin
                    w_shift = 1'b1;
                end else if (r_frames != '0) begin
                    w_reload = 1'b1;
`ifdef SEQ_TX_GAP_EN
                    w_ns     = ST_GAP;
`else
                    w_ns     = ST_SHIFT;
`endif
                end else begin
                    w_ns = ST_DONE;
                end
            end
`ifdef SEQ_TX_GAP_EN
            ST_GAP:  w_ns = ST_SHIFT;
`endif
            ST_DONE: w_ns = ST_IDLE;
            default: w_ns = ST_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_frames    <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_ns;
            if (w_load) begin
                r_frames <= bus.repeat_n;
            end else if (w_reload) begin
                r_frames <= r_frames - CNT_W'(1);
            end
            r_out_valid <= (w_ns == ST_SHIFT);
            r_busy      <= (w_ns != ST_IDLE);
            r_done      <= (w_ns == ST_DONE);
        end
    end

    seq_tx_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_reload   (w_reload),
        .i_shift    (w_shift),
        .i_pattern  (bus.pattern),
        .o_msb      (w_msb),
        .o_bit_zero (w_bit_zero)
    );

    assign bus.out       = r_out_valid & w_msb;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.cs        = r_state;
    assign bus.ns        = w_ns;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus queues one expected token per busy
// cycle, and a negedge monitor pops and compares while the DUT reports busy.
module tb_seq_pattern_tx;

    localparam int W = 4;
    localparam int C = 4;

    typedef struct packed {
        logic v;
        logic b;
        logic d;
    } tok_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    tok_t exp_q[$];

    seq_pattern_tx_if #(.WIDTH(W), .CNT_W(C)) bus ();

    seq_pattern_tx #(.WIDTH(W), .CNT_W(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every busy cycle must match the next expected token; idle cycles must be quiet.
    always @(negedge clk) begin
        tok_t t;
        if (!rst) begin
            if (bus.busy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_busy: busy=1 cs=%0d with no expected token, required busy=0", bus.cs);
                end else begin
                    t = exp_q.pop_front();
                    if (bus.out_valid !== t.v || bus.out !== t.b || bus.done !== t.d) begin
                        errors++;
                        $display("FAIL stream: got valid/out/done=%b%b%b required %b%b%b at %0t",
                                 bus.out_valid, bus.out, bus.done, t.v, t.b, t.d, $time);
                    end
                end
            end else begin
                checks++;
                if ({bus.out_valid, bus.out, bus.done} !== 3'b000) begin
                    errors++;
                    $display("FAIL idle_quiet: got valid/out/done=%b%b%b required 000 at %0t",
                             bus.out_valid, bus.out, bus.done, $time);
                end
            end
        end
    end

    task automatic check1(input string name, input logic [2:0] got, input logic [2:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic push_frames(input logic [W-1:0] pat, input logic [C-1:0] rep);
        for (int f = 0; f <= int'(rep); f++) begin
`ifdef SEQ_TX_GAP_EN
            if (f > 0) exp_q.push_back('{v: 1'b0, b: 1'b0, d: 1'b0});
`endif
            for (int i = W - 1; i >= 0; i--) exp_q.push_back('{v: 1'b1, b: pat[i], d: 1'b0});
        end
        exp_q.push_back('{v: 1'b0, b: 1'b0, d: 1'b1});
    endtask

    // Present start for one sampling edge; afterwards scramble the request inputs.
    task automatic do_start(input logic [W-1:0] pat, input logic [C-1:0] rep, input bit hold);
        @(posedge clk); #2;
        bus.start    = 1'b1;
        bus.pattern  = pat;
        bus.repeat_n = rep;
        push_frames(pat, rep);
        @(posedge clk); #2;
        if (!hold) begin
            bus.start    = 1'b0;
            bus.pattern  = W'($urandom);
            bus.repeat_n = C'($urandom);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || bus.busy) begin
            errors++;
            $display("FAIL %s_timeout: pending=%0d busy=%b required 0 and 0", name, exp_q.size(), bus.busy);
            exp_q.delete();
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.pattern  = '0;
        bus.repeat_n = '0;
        #1;
        check1("rst_out",       {2'b00, bus.out},       3'd0);
        check1("rst_out_valid", {2'b00, bus.out_valid}, 3'd0);
        check1("rst_busy",      {2'b00, bus.busy},      3'd0);
        check1("rst_done",      {2'b00, bus.done},      3'd0);
        check1("rst_cs",        bus.cs,                 3'd0);
        check1("rst_ns",        bus.ns,                 3'd0);
        #16 rst = 1'b0;

        // Single frame 1010: four bits, then done, then idle.
        do_start(4'b1010, 4'd0, 1'b0);
        check1("cs_shift", bus.cs, 3'd1);
        wait_idle("single", 40);

        // Three frames of 1010 (gap between frames when enabled).
        do_start(4'b1010, 4'd2, 1'b0);
        wait_idle("repeat2", 60);

        // start held high and pattern changed mid-frame: frame is unaffected, no restart while busy.
        do_start(4'b1010, 4'd0, 1'b1);
        bus.pattern = 4'b0110;
        for (int k = 0; k < 20; k++) begin
            if (bus.done) break;
            @(posedge clk); #2;
        end
        bus.start = 1'b0;
        wait_idle("held_start", 40);

        // Maximum repeat count: sixteen frames of 1001.
        do_start(4'b1001, 4'hF, 1'b0);
        wait_idle("max_repeat", 200);

        // Asynchronous reset after the second bit aborts the frame with no done.
        do_start(4'b1100, 4'd0, 1'b0);
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check1("abort_out_valid", {2'b00, bus.out_valid}, 3'd0);
        check1("abort_busy",      {2'b00, bus.busy},      3'd0);
        check1("abort_cs",        bus.cs,                 3'd0);
        exp_q.delete();
        @(posedge clk); #3;
        rst = 1'b0;
        do_start(4'b0110, 4'd1, 1'b0);
        wait_idle("after_abort", 60);

        // A few more distinct patterns.
        do_start(4'b1111, 4'd0, 1'b0);
        wait_idle("ones", 40);
        do_start(4'b0001, 4'd1, 1'b0);
        wait_idle("low_msb", 40);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
